// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (double-dabble, one bit per clock).
// Optional two's-complement input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bcd,
  output logic             overflow,
  output logic             neg
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] mag_next;
  logic [39:0]      acc_reg;
  logic [39:0]      acc_adj;
  logic [39:0]      acc_next;
  logic [4:0]       cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [31:0]      bcd_reg;
  logic             overflow_reg;

  // Ten parallel add-3 correctors; the extra two digits expose overflow past 99 999 999.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ? acc_reg[gi*4 +: 4] + 4'd3
                                                                : acc_reg[gi*4 +: 4];
    end
  endgenerate

  assign acc_next = {acc_adj[38:0], shift_reg[WIDTH-1]};

`ifdef BIN2BCD_SIGNED_EN
  logic sign_next;
  logic sign_reg;
  logic neg_reg;

  assign mag_next  = data[WIDTH-1] ? (~data + WIDTH'(1)) : data;
  assign sign_next = data[WIDTH-1];
  assign neg       = neg_reg;
`else
  assign mag_next  = data;
  assign neg       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_reg     <= 1'b0;
      neg_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg <= mag_next;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            sign_reg  <= sign_next;
`endif
          end
        end
        SHIFT: begin
          acc_reg   <= acc_next;
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          cnt_reg   <= cnt_reg + 5'd1;
          // Last shift: publish the post-shift accumulator directly.
          if (cnt_reg == 5'd31) begin
            bcd_reg      <= acc_next[31:0];
            overflow_reg <= |acc_next[39:32];
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
`ifdef BIN2BCD_SIGNED_EN
            neg_reg      <= sign_reg;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a monitor checks each done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;
  logic        neg;

  typedef struct {
    logic [31:0] bcd;
    logic        ov;
    logic        neg;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef BIN2BCD_SIGNED_EN
  localparam logic SIGNED_BUILD = 1'b1;
`else
  localparam logic SIGNED_BUILD = 1'b0;
`endif

  bin2bcd_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start at the current negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] d, input logic [31:0] e_bcd, input logic e_ov,
                       input logic e_neg);
    exp_t e;
    start = 1'b1;
    data  = d;
    e.bcd = e_bcd;
    e.ov  = e_ov;
    e.neg = e_neg;
    e.due = edge_cnt + 33;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    data  = $urandom;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {39'd0, ok}, 40'd1);
  endtask

  // Monitor: every done must match the oldest outstanding expectation, including its timing.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 40'd1, 40'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn: bcd=%h overflow=%b neg=%b at edge %0d (expected %h/%b/%b at %0d)",
                 bcd, overflow, neg, edge_cnt, e.bcd, e.ov, e.neg, e.due);
        check("bcd", {8'd0, bcd}, {8'd0, e.bcd});
        check("overflow", {39'd0, overflow}, {39'd0, e.ov});
        check("neg", {39'd0, neg}, {39'd0, e.neg});
        check("latency", 40'(edge_cnt), 40'(e.due));
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    data  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {39'd0, busy}, 40'd0);
    check("reset_done", {39'd0, done}, 40'd0);
    check("reset_bcd", {8'd0, bcd}, 40'd0);
    check("reset_ovf_neg", {38'd0, overflow, neg}, 40'd0);
    reset = 1'b1;
    @(negedge clk);

    // Zero conversion with explicit busy window and done timing.
    issue(32'd0, 32'h00000000, 1'b0, 1'b0);
    check("busy_first", {39'd0, busy}, 40'd1);
    repeat (31) @(negedge clk);
    check("busy_last", {38'd0, busy, done}, 40'b10);
    @(negedge clk);
    check("busy_drop_done", {38'd0, busy, done}, 40'b01);
    wait_idle("idle_zero");

    @(negedge clk);
    issue(32'd12345678, 32'h12345678, 1'b0, 1'b0);
    wait_idle("idle_12345678");
    @(negedge clk);
    issue(32'd99999999, 32'h99999999, 1'b0, 1'b0);
    wait_idle("idle_99999999");
    @(negedge clk);
    issue(32'd100000000, 32'h00000000, 1'b1, 1'b0);
    wait_idle("idle_100000000");
    @(negedge clk);
    if (SIGNED_BUILD) issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    else              issue(32'hFFFFFFFF, 32'h94967295, 1'b1, 1'b0);
    wait_idle("idle_ffffffff");
    @(negedge clk);
    issue(32'h80000000, 32'h47483648, 1'b1, SIGNED_BUILD);
    wait_idle("idle_80000000");

    // Start mid-conversion is ignored; start held in the done cycle is accepted.
    @(negedge clk);
    issue(32'd1234, 32'h00001234, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    data  = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("done_first", {39'd0, done}, 40'd1);
    issue(32'd87654321, 32'h87654321, 1'b0, 1'b0);
    wait_idle("idle_back_to_back");

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    issue(32'd12345678, 32'h12345678, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {39'd0, busy}, 40'd0);
    check("abort_bcd", {8'd0, bcd}, 40'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", {38'd0, busy, done}, 40'd0);
    issue(32'd42, 32'h00000042, 1'b0, 1'b0);
    wait_idle("idle_42");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
